// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the RISCV32I memory-side blocks.
package riscv_mem_pkg;

    // Default data word width of the processor RAM
    localparam int DATA_W = 32;

    // Number of byte lanes in a data word
    localparam int BE_W = DATA_W / 8;

    // Byte enable value used for full-word accesses (instruction fetch)
    localparam logic [BE_W-1:0] ALL_BE = '1;

    // Width of the IF starvation counter
    localparam int STARVE_CNT_W = 4;

    // Which requester owns the read response returning next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter: clear has priority over increment,
// the count holds when neither is asserted. o_limit flags count >= Limit.
module arb_starve_ctr
    import riscv_mem_pkg::*;
#(
    parameter int Limit = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit
);

    localparam logic [STARVE_CNT_W-1:0] L_LIMIT = STARVE_CNT_W'(Limit);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count denied cycles, saturating at the limit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < L_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_limit = (r_cnt >= L_LIMIT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port RAM between instruction fetch (IF) and the
// load/store unit (LS). LS has fixed priority; IF wins once it has been
// denied StarveLimit consecutive ready cycles. Read data returns one cycle
// after the grant and is steered to the requester that issued the read.
module ram_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32,
    parameter int StarveLimit = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_ram_ready,
    input  logic                   i_if_req,
    input  logic [RAMAddrSize-1:0] i_if_addr,
    output logic                   o_if_gnt,
    output logic                   o_if_rvalid,
    output logic [dataW-1:0]       o_if_rdata,
    input  logic                   i_ls_req,
    input  logic                   i_ls_we,
    input  logic [dataW/8-1:0]     i_ls_be,
    input  logic [RAMAddrSize-1:0] i_ls_addr,
    input  logic [dataW-1:0]       i_ls_wdata,
    output logic                   o_ls_gnt,
    output logic                   o_ls_rvalid,
    output logic [dataW-1:0]       o_ls_rdata,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic [dataW/8-1:0]     o_ram_be,
    output logic [RAMAddrSize-1:0] o_ram_addr,
    output logic [dataW-1:0]       o_ram_wdata,
    input  logic [dataW-1:0]       i_ram_rdata
);

    localparam int BW = dataW / 8;

    logic [BW-1:0] w_all_be;
    logic          w_starved;
    logic          w_if_gnt;
    logic          w_ls_gnt;
    logic          w_cnt_inc;
    logic          w_cnt_clr;

    owner_t r_owner;
    logic   r_if_rvalid;
    logic   r_ls_rvalid;

    // Reuse the shared full-word enable when the widths agree
    generate
        if (BW == BE_W) begin : g_pkg_be
            assign w_all_be = ALL_BE;
        end else begin : g_local_be
            assign w_all_be = '1;
        end
    endgenerate

    // IF wins when it is alone or has waited long enough; LS wins otherwise
    assign w_if_gnt = i_ram_ready & i_if_req & (~i_ls_req | w_starved);
    assign w_ls_gnt = i_ram_ready & i_ls_req & ~(i_if_req & w_starved);

    // A withdrawn IF request or a served one restarts the wait count;
    // cycles where the RAM is busy neither count nor clear.
    assign w_cnt_clr = w_if_gnt | ~i_if_req;
    assign w_cnt_inc = i_if_req & ~w_if_gnt & i_ram_ready;

    arb_starve_ctr #(
        .Limit (StarveLimit)
    ) u_starve_ctr (
        .i_clk   (i_clock),
        .i_rst_n (i_reset),
        .i_inc   (w_cnt_inc),
        .i_clr   (w_cnt_clr),
        .o_limit (w_starved)
    );

    // Steer the winner's access onto the RAM port; idle port drives zeros
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_be    = '0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (w_ls_gnt) begin
            o_ram_we    = i_ls_we;
            o_ram_be    = i_ls_be;
            o_ram_addr  = i_ls_addr;
            o_ram_wdata = i_ls_wdata;
        end else if (w_if_gnt) begin
            o_ram_be    = w_all_be;
            o_ram_addr  = i_if_addr;
        end
    end

    assign o_ram_en = w_if_gnt | w_ls_gnt;
    assign o_if_gnt = w_if_gnt;
    assign o_ls_gnt = w_ls_gnt;

    // Remember who issued this cycle's read so next cycle's data goes there
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_owner     <= OWN_NONE;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ls_rvalid <= w_ls_gnt & ~i_ls_we;
            if (w_if_gnt) begin
                r_owner <= OWN_IF;
            end else if (w_ls_gnt && !i_ls_we) begin
                r_owner <= OWN_LS;
            end else begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign o_if_rvalid = r_if_rvalid;
    assign o_ls_rvalid = r_ls_rvalid;
    assign o_if_rdata  = (r_owner == OWN_IF) ? i_ram_rdata : '0;
    assign o_ls_rdata  = (r_owner == OWN_LS) ? i_ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a response scoreboard.
module tb_ram_port_arbiter;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_ready;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        owner_t      own;
        logic [31:0] data;
    } resp_t;
    resp_t sb_q[$];

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .dataW(32), .RAMAddrSize(32), .StarveLimit(4)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_ram_ready(ram_ready),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be),
        .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata), .o_ls_gnt(ls_gnt),
        .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_be(ram_be),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] ram_fn(input logic [31:0] a);
        return a ^ 32'hA500_0013;
    endfunction

    // RAM model: read data one cycle after a read strobe, junk otherwise
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= ram_fn(ram_addr);
        else                   ram_rdata <= 32'hBAD0_0BAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven; check at negedge, then advance
    task automatic step(input bit e_if, input bit e_ls);
        resp_t r;
        bit    got;
        @(negedge clk);
        got = (sb_q.size() != 0);
        if (got) r = sb_q.pop_front();
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, got && r.own == OWN_IF});
        chk("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, got && r.own == OWN_LS});
        chk("if_rdata", if_rdata, (got && r.own == OWN_IF) ? r.data : 32'h0);
        chk("ls_rdata", ls_rdata, (got && r.own == OWN_LS) ? r.data : 32'h0);
        chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
        chk("ls_gnt", {31'b0, ls_gnt}, {31'b0, e_ls});
        chk("ram_en", {31'b0, ram_en}, {31'b0, e_if | e_ls});
        if (e_if) begin
            chk("ram_addr", ram_addr, if_addr);
            chk("ram_we", {31'b0, ram_we}, 32'h0);
            chk("ram_be", {28'b0, ram_be}, 32'hF);
            sb_q.push_back('{OWN_IF, ram_fn(if_addr)});
        end else if (e_ls) begin
            chk("ram_addr", ram_addr, ls_addr);
            chk("ram_we", {31'b0, ram_we}, {31'b0, ls_we});
            chk("ram_be", {28'b0, ram_be}, {28'b0, ls_be});
            chk("ram_wdata", ram_wdata, ls_wdata);
            if (!ls_we) sb_q.push_back('{OWN_LS, ram_fn(ls_addr)});
        end else begin
            chk("ram_addr", ram_addr, 32'h0);
            chk("ram_be", {28'b0, ram_be}, 32'h0);
            chk("ram_wdata", ram_wdata, 32'h0);
        end
        $display("cycle t=%0t if_gnt=%b ls_gnt=%b if_rv=%b ls_rv=%b addr=%h",
                 $time, if_gnt, ls_gnt, if_rvalid, ls_rvalid, ram_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ram_ready = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        @(posedge clk); #1;
        // Reset state: nothing requested, everything quiet
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);

        // Reset while an IF read response is pending
        if_req = 1'b1; if_addr = 32'h10;
        step(1, 0);
        rst_n = 1'b0; if_req = 1'b0;
        sb_q.delete();
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);

        // IF only
        if_req = 1'b1; if_addr = 32'h40;
        step(1, 0);
        if_req = 1'b0;
        step(0, 0);

        // LS write: no response afterwards
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
        step(0, 1);
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_wdata = 32'h0;
        step(0, 0);

        // Contention: LS four times, then IF, then LS again
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            step(0, 1);
            ls_addr = ls_addr + 32'h4;
        end
        step(1, 0);
        if_addr = 32'h204;
        step(0, 1);
        if_req = 1'b0; ls_req = 1'b0;
        step(0, 0);

        // Back-pressure: count holds while RAM is busy, response still lands
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_addr = 32'h500;
        step(0, 1);
        ls_addr = 32'h504;
        step(0, 1);
        ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0);
        ram_ready = 1'b1;
        ls_addr = 32'h508;
        step(0, 1);
        ls_addr = 32'h50C;
        step(0, 1);
        step(1, 0);
        if_req = 1'b0; ls_req = 1'b0;
        step(0, 0);

        // Withdrawn IF request clears the wait count
        if_req = 1'b1; if_addr = 32'h600;
        ls_req = 1'b1; ls_addr = 32'h700;
        step(0, 1);
        step(0, 1);
        if_req = 1'b0;
        step(0, 1);
        if_req = 1'b1; if_addr = 32'h604;
        for (int i = 0; i < 4; i++) begin
            ls_addr = ls_addr + 32'h4;
            step(0, 1);
        end
        step(1, 0);
        if_req = 1'b0; ls_req = 1'b0;
        step(0, 0);
        step(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
